// File: rtl/weight_stream_source_if.sv
// Weight beat stream towards the weight buffer plus the weight SRAM read port.
// The master side is the stream source; the slave side is the buffer/SRAM.
interface weight_stream_source_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              mem_req;
   logic              mem_data_valid;
   logic [63:0]       weight_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [63:0]       rd_data;
   logic              rd_valid;

   modport master (
      input  mem_req, rd_data, rd_valid,
      output mem_data_valid, weight_data, rd_en, rd_addr
   );

   modport slave (
      output mem_req, rd_data, rd_valid,
      input  mem_data_valid, weight_data, rd_en, rd_addr
   );
endinterface

// File: rtl/weight_stream_source.sv
// Streams N 64-bit weight words from a fixed-latency SRAM through a small credit-managed FIFO.
// cur_mode encoding: 0=MODE1, 1=MODE2, 2=MODE3, 3=MODE4.
module weight_stream_source #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             cur_mode,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic                   flush,
   output logic                   busy,
   output logic                   done,
   weight_stream_source_if.master bus
);

   localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned BeatW = 7;

   localparam logic [1:0] Mode1 = 2'd0;
   localparam logic [1:0] Mode2 = 2'd1;
   localparam logic [1:0] Mode3 = 2'd2;
   localparam logic [1:0] Mode4 = 2'd3;

   typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

   state_e            state_q;
   logic [1:0]        mode_q;
   logic [BeatW-1:0]  n_q;
   logic [ADDR_W-1:0] base_q;
   logic [BeatW-1:0]  issue_cnt_q;
   logic [BeatW-1:0]  xfer_cnt_q;
   logic              push_odd_q;
   logic [CntW-1:0]   inflight_q;
   logic [CntW-1:0]   drop_cnt_q;
   logic              busy_q;
   logic              done_q;

   logic [63:0]       fifo_mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q;
   logic [PtrW-1:0]   rd_ptr_q;
   logic [CntW-1:0]   fifo_cnt_q;

   logic              rd_en;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              mem_data_valid;
   logic              credit_ok;
   logic [CntW:0]     credit_sum;
   logic [63:0]       push_data;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [BeatW-1:0] beats_for(input logic [1:0] mode);
      logic [BeatW-1:0] n;
      unique case (mode)
         Mode1, Mode2: n = BeatW'(88);
         Mode3:        n = BeatW'(20);
         Mode4:        n = BeatW'(12);
         default:      n = BeatW'(88);
      endcase
      return n;
   endfunction

   always_comb begin
      credit_sum     = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
      credit_ok      = credit_sum < (CntW + 1)'(FIFO_DEPTH);
      // Reads stay blocked until every stale return from an aborted stream has drained.
      rd_en          = (state_q == StStream) && !flush && (drop_cnt_q == '0) &&
                       (issue_cnt_q < n_q) && credit_ok;
      fifo_push      = bus.rd_valid && (drop_cnt_q == '0);
      fifo_full      = (fifo_cnt_q == CntW'(FIFO_DEPTH));
      mem_data_valid = (state_q == StStream) && (fifo_cnt_q != '0);
      fifo_pop       = mem_data_valid && bus.mem_req;
      // Second beat of a MODE1/MODE2 row only carries 24 meaningful bits.
      if (((mode_q == Mode1) || (mode_q == Mode2)) && push_odd_q) begin
         push_data = {40'b0, bus.rd_data[23:0]};
      end else begin
         push_data = bus.rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= StIdle;
         mode_q      <= Mode1;
         n_q         <= '0;
         base_q      <= '0;
         issue_cnt_q <= '0;
         xfer_cnt_q  <= '0;
         push_odd_q  <= 1'b0;
         inflight_q  <= '0;
         drop_cnt_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
      end else if (flush) begin
         state_q     <= StIdle;
         issue_cnt_q <= '0;
         xfer_cnt_q  <= '0;
         push_odd_q  <= 1'b0;
         inflight_q  <= '0;
         // A return arriving in this very cycle is discarded here, not counted.
         drop_cnt_q  <= drop_cnt_q + inflight_q - CntW'(bus.rd_valid);
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
      end else begin
         done_q <= 1'b0;

         if (rd_en) begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
         end
         inflight_q <= inflight_q + CntW'(rd_en) - CntW'(fifo_push);
         if (bus.rd_valid && (drop_cnt_q != '0)) begin
            drop_cnt_q <= drop_cnt_q - 1'b1;
         end

         if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q             <= ptr_inc(wr_ptr_q);
            push_odd_q           <= ~push_odd_q;
         end
         if (fifo_pop) begin
            rd_ptr_q   <= ptr_inc(rd_ptr_q);
            xfer_cnt_q <= xfer_cnt_q + 1'b1;
         end
         if (fifo_push && !fifo_pop) begin
            fifo_cnt_q <= fifo_cnt_q + 1'b1;
         end else if (!fifo_push && fifo_pop) begin
            fifo_cnt_q <= fifo_cnt_q - 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q     <= StStream;
                  mode_q      <= cur_mode;
                  n_q         <= beats_for(cur_mode);
                  base_q      <= base_addr;
                  issue_cnt_q <= '0;
                  xfer_cnt_q  <= '0;
                  push_odd_q  <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            StStream: begin
               if (fifo_pop && ((xfer_cnt_q + 1'b1) == n_q)) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Shadow of issued reads, used only to check the SRAM latency contract.
   logic [RD_LATENCY-1:0] rd_pipe_q;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         rd_pipe_q <= '0;
      end else begin
         rd_pipe_q <= RD_LATENCY'({rd_pipe_q, rd_en});
      end
   end

   assert property (@(posedge clk) disable iff (rst_n)
      !(fifo_push && !fifo_pop && fifo_full));

   assert property (@(posedge clk) disable iff (rst_n)
      bus.rd_valid == rd_pipe_q[RD_LATENCY-1]);

   assign bus.rd_en          = rd_en;
   assign bus.rd_addr        = base_q + ADDR_W'(issue_cnt_q);
   assign bus.mem_data_valid = mem_data_valid;
   assign bus.weight_data    = (fifo_cnt_q != '0) ? fifo_mem_q[rd_ptr_q] : '0;
   assign busy               = busy_q;
   assign done               = done_q;

endmodule

// File: doc/weight_stream_source.md
Name: weight_stream_source

Overview:
- Memory-side producer of the 64-bit weight beat stream consumed by the weight buffer.
- On a start pulse, latches the operating mode and a base word address.
- Reads the required number of 64-bit words from a fixed-latency on-chip weight SRAM read port, buffers them in a small FIFO, and presents them as mem_data_valid/weight_data.
- A beat is transferred only in a cycle where the weight buffer holds mem_req high.

Parameters:
ADDR_W, 16, word address width of the weight SRAM (one word = 64 bits)
RD_LATENCY, 2, cycles from rd_en to rd_valid; fixed, >=1
FIFO_DEPTH, 4, beat FIFO entries; must be >= RD_LATENCY+1

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-high reset (despite the name)
cur_mode  input  OP_MODE  mode; sampled only on accepted start
start  input  1  one-cycle pulse; begins a transfer when IDLE
base_addr  input  ADDR_W  first SRAM word address; sampled with start
flush  input  1  abort, driven from free_weight_buffer; synchronous
mem_req  input  1  weight buffer wants data; a beat transfers when mem_data_valid && mem_req
mem_data_valid  output  1  FIFO head is valid
weight_data  output  64  FIFO head beat
rd_en  output  1  SRAM read strobe
rd_addr  output  ADDR_W  SRAM read address
rd_data  input  64  SRAM read data
rd_valid  input  1  rd_data valid, exactly RD_LATENCY cycles after rd_en
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse in the cycle after the last beat transfers

Behaviour:
- Reset (rst_n=1): state IDLE. FIFO is empty. All counters are 0. The inflight count, the drop count and all outputs are 0.
- Beat total N (latched at start):
  - MODE1/MODE2: 88 (44 rows x 2 beats).
  - MODE3: 20.
  - MODE4: 12.
- States: IDLE, STREAM, DONE.
  - IDLE -> STREAM on start. Latch mode, N and base_addr. Clear issue_cnt and xfer_cnt.
  - start is ignored outside IDLE.
- Read issue (STREAM only):
  - rd_en=1 when issue_cnt<N and fifo_count+inflight<FIFO_DEPTH.
  - rd_addr = base_addr + issue_cnt. Arithmetic is modulo 2^ADDR_W; wrap is allowed.
  - issue_cnt increments on each rd_en.
  - inflight increments on rd_en and decrements on rd_valid. Both in the same cycle leaves it unchanged.
- FIFO push on rd_valid when drop_cnt==0.
  - The FIFO never overflows, by the credit rule above.
  - Reaching overflow is an assertion failure.
- Data shaping at push:
  - MODE1/MODE2, odd beat index (the second beat of a row): bits [63:24] are forced to 0.
  - Otherwise the word is pushed unmodified.
- Output:
  - mem_data_valid = (state==STREAM) && FIFO non-empty.
  - weight_data = FIFO head; it is 0 when the FIFO is empty.
  - Pop and xfer_cnt++ when mem_data_valid && mem_req.
  - Push and pop in the same cycle are both allowed, including when the FIFO is full.
- mem_req low stalls the output. Reads continue until the FIFO credits are exhausted; no beat is lost or duplicated.
- Completion:
  - When a pop makes xfer_cnt==N, go to DONE.
  - DONE: done=1 for that one cycle, busy=0, then IDLE.
  - busy=1 in STREAM only.
- flush (priority below reset, above all else):
  - FIFO is emptied, state goes to IDLE, counters are cleared, and no done pulse is produced.
  - drop_cnt is loaded with the current inflight. Subsequent rd_valid returns are discarded, each decrementing drop_cnt.
  - While drop_cnt!=0, a new start is accepted, but no rd_en is issued until drop_cnt==0.
- flush and start in the same cycle: flush wins and start is ignored.
- mem_req may be high while the FIFO is empty; this has no effect.
- N is never exceeded: there are no reads beyond issue_cnt==N.

Test Plan:
1. MODE3, base_addr=0x0100, mem_req held 1, SRAM word[a]=a -> rd_addr 0x0100..0x0113 issued. 20 beats transfer with weight_data=0x100..0x113 in order. done pulses one cycle after the 20th transfer. busy falls with done.
2. MODE1, base_addr=0, SRAM words all 0xFFFF_FFFF_FFFF_FFFF -> 88 transfers. Even beats = all-ones; odd beats = 0x0000_0000_00FF_FFFF. done pulses after the 88th.
3. MODE4, mem_req toggled 1/0 every 3 cycles -> exactly 12 transfers, in address order. rd_en stalls once fifo_count+inflight==4. No transfer occurs while mem_req=0.
4. base_addr=0xFFFA, MODE4 -> rd_addr sequence 0xFFFA..0xFFFF, 0x0000..0x0005.
5. MODE1 stream, flush asserted with 2 reads inflight, then start MODE3 next cycle -> the 2 stale rd_valid returns are dropped. The first new beat equals the new base_addr word. No done is produced for the aborted stream.
6. rst_n=1 mid-stream and start in the same cycle -> all outputs 0, state IDLE. A later start completes normally.
